// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: request kinds, opcodes, functs and field positions.
// Used by the instruction encoder and the core's control decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpSlt  = 4'd4,
    OpLw   = 4'd5,
    OpSw   = 4'd6,
    OpBeq  = 4'd7,
    OpAddi = 4'd8,
    OpJ    = 4'd9
  } op_kind_e;

  localparam logic [5:0] OpcRtype = 6'b000000;
  localparam logic [5:0] OpcLw    = 6'b100011;
  localparam logic [5:0] OpcSw    = 6'b101011;
  localparam logic [5:0] OpcBeq   = 6'b000100;
  localparam logic [5:0] OpcAddi  = 6'b001000;
  localparam logic [5:0] OpcJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // Least-significant bit of each instruction field
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned ShamtLsb  = 6;
  localparam int unsigned FunctLsb  = 0;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    logic [31:0] w;
    w = '0;
    w[OpcodeLsb +: 6] = OpcRtype;
    w[RsLsb +: 5]     = rs;
    w[RtLsb +: 5]     = rt;
    w[RdLsb +: 5]     = rd;
    w[ShamtLsb +: 5]  = 5'd0;
    w[FunctLsb +: 6]  = funct;
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opcode, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OpcodeLsb +: 6] = opcode;
    w[RsLsb +: 5]     = rs;
    w[RtLsb +: 5]     = rt;
    w[15:0]           = imm;
    return w;
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OpcodeLsb +: 6] = OpcJ;
    w[25:0]           = target;
    return w;
  endfunction

endpackage

// File: rtl/mips_instr_fmt.sv
// Combinational formatter: maps a request kind plus operand fields to a 32-bit MIPS word.
// legal_o is low for kinds outside the defined set; word_o is then zero.
module mips_instr_fmt
  import mips_pkg::*;
(
  input  logic [3:0]  op_kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (op_kind_i)
      OpAdd:   word_o = enc_r(rs_i, rt_i, rd_i, FunctAdd);
      OpSub:   word_o = enc_r(rs_i, rt_i, rd_i, FunctSub);
      OpAnd:   word_o = enc_r(rs_i, rt_i, rd_i, FunctAnd);
      OpOr:    word_o = enc_r(rs_i, rt_i, rd_i, FunctOr);
      OpSlt:   word_o = enc_r(rs_i, rt_i, rd_i, FunctSlt);
      OpLw:    word_o = enc_i(OpcLw, rs_i, rt_i, imm_i);
      OpSw:    word_o = enc_i(OpcSw, rs_i, rt_i, imm_i);
      OpBeq:   word_o = enc_i(OpcBeq, rs_i, rt_i, imm_i);
      OpAddi:  word_o = enc_i(OpcAddi, rs_i, rt_i, imm_i);
      OpJ:     word_o = enc_j(target_i);
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes symbolic requests and streams words into instruction memory.
// Define INSTR_ENC_CHECKSUM_EN to add a running-XOR Checksum output.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  Finish,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [3:0]            Op_Kind,
  input  logic [4:0]            Rs,
  input  logic [4:0]            Rt,
  input  logic [4:0]            Rd,
  input  logic [15:0]           Imm,
  input  logic [25:0]           Target,
  output logic                  Mem_WE,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [31:0]           Mem_WData,
  output logic [ADDR_WIDTH-2:0] Count,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [31:0]           Checksum
`endif
);

  localparam int unsigned           Depth    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [ADDR_WIDTH-2:0] DepthCnt = (ADDR_WIDTH - 1)'(Depth);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-2:0] count_q, count_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           fmt_word;
  logic                  fmt_legal;
  logic                  accept;

  mips_instr_fmt u_fmt (
    .op_kind_i (Op_Kind),
    .rs_i      (Rs),
    .rt_i      (Rt),
    .rd_i      (Rd),
    .imm_i     (Imm),
    .target_i  (Target),
    .word_o    (fmt_word),
    .legal_o   (fmt_legal)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    In_Ready = (state_q == StLoad) && !Finish && (count_q < DepthCnt);
    accept   = In_Valid && In_Ready;

    if (Start) begin
      // Restart wins over Finish and drops any request accepted this cycle
      state_d = StLoad;
      ptr_d   = BaseAddr;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        StLoad:  if (Finish || (count_q == DepthCnt)) state_d = StDone;
        default: state_d = state_q;
      endcase
      if (accept) begin
        if (fmt_legal) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = fmt_word;
          ptr_d   = ptr_q + ADDR_WIDTH'(4);
          count_d = count_q + (ADDR_WIDTH - 1)'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      ptr_q   <= BaseAddr;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BaseAddr;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign Mem_WE    = we_q;
  assign Mem_Addr  = addr_q;
  assign Mem_WData = wdata_q;
  assign Count     = count_q;
  assign Busy      = (state_q == StLoad);
  assign Done      = (state_q == StDone);
  assign Err       = err_q;

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (Start) begin
      chk_d = '0;
    end else if (accept && fmt_legal) begin
      chk_d = chk_q ^ fmt_word;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign Checksum = chk_q;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: scoreboarded writes plus per-scenario checks.
// Optional Checksum checks follow INSTR_ENC_CHECKSUM_EN.
module tb_mips_instr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared request fields
  logic [3:0]  op_kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  // Main instance (ADDR_WIDTH 8)
  logic        start = 0, finish = 0, in_valid = 0;
  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;

  // Small instance (ADDR_WIDTH 4, DEPTH 4)
  logic        s_start = 0, s_finish = 0, s_valid = 0;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [3:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] checksum, s_checksum;
`endif

  mips_instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .CLK(clk), .RST(rst_n), .Start(start), .Finish(finish), .In_Valid(in_valid),
    .In_Ready(in_ready), .Op_Kind(op_kind), .Rs(rs), .Rt(rt), .Rd(rd), .Imm(imm),
    .Target(target), .Mem_WE(mem_we), .Mem_Addr(mem_addr), .Mem_WData(mem_wdata),
    .Count(count), .Busy(busy), .Done(done), .Err(err)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .Checksum(checksum)
`endif
  );

  mips_instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(0)) dut_s (
    .CLK(clk), .RST(rst_n), .Start(s_start), .Finish(s_finish), .In_Valid(s_valid),
    .In_Ready(s_ready), .Op_Kind(op_kind), .Rs(rs), .Rt(rt), .Rd(rd), .Imm(imm),
    .Target(target), .Mem_WE(s_we), .Mem_Addr(s_addr), .Mem_WData(s_wdata),
    .Count(s_count), .Busy(s_busy), .Done(s_done), .Err(s_err)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .Checksum(s_checksum)
`endif
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        q_s[$];
  exp_t        mon_e, mon_se;
  logic [7:0]  exp_ptr = '0;
  logic [7:0]  s_exp_ptr = '0;
  logic [7:0]  s_max_addr = '0;
  logic [31:0] s_xor = '0;
  int          s_writes = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] model_enc(input logic [3:0] k, input logic [4:0] s,
                                            input logic [4:0] t, input logic [4:0] d,
                                            input logic [15:0] im, input logic [25:0] tg);
    logic [5:0] f;
    case (k)
      4'd0:    f = 6'h20;
      4'd1:    f = 6'h22;
      4'd2:    f = 6'h24;
      4'd3:    f = 6'h25;
      4'd4:    f = 6'h2A;
      default: f = 6'h00;
    endcase
    case (k)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: return {6'h00, s, t, d, 5'd0, f};
      4'd5:    return {6'h23, s, t, im};
      4'd6:    return {6'h2B, s, t, im};
      4'd7:    return {6'h04, s, t, im};
      4'd8:    return {6'h08, s, t, im};
      4'd9:    return {6'h02, tg};
      default: return 32'h0;
    endcase
  endfunction

  // Scoreboard monitors: every write strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
          bad++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_we) begin
      total++;
      s_writes++;
      if ({4'b0, s_addr} > s_max_addr) s_max_addr = {4'b0, s_addr};
      if (q_s.size() == 0) begin
        bad++;
        $display("FAIL small_unexpected_write: got addr=%h data=%h, required no write",
                 s_addr, s_wdata);
      end else begin
        mon_se = q_s.pop_front();
        if ({4'b0, s_addr} !== mon_se.addr || s_wdata !== mon_se.data) begin
          bad++;
          $display("FAIL small_write: got addr=%h data=%h, required addr=%h data=%h",
                   s_addr, s_wdata, mon_se.addr, mon_se.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    s_valid  = 0;
    repeat (n) tick();
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start   = 0;
    exp_ptr = '0;
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
    logic legal;
    legal   = (k <= 4'd9);
    op_kind = k; rs = s; rt = t; rd = d; imm = im; target = tg;
    in_valid = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: got %b, required 1", in_ready);
    end
    if (legal) begin
      q.push_back('{addr: exp_ptr, data: model_enc(k, s, t, d, im, tg)});
      exp_ptr += 8'd4;
    end
    @(posedge clk);
    #1;
    total++;
    if (mem_we !== legal) begin
      bad++;
      $display("FAIL send_we: got %b, required %b", mem_we, legal);
    end
  endtask

  task automatic check_queue(input string name);
    total++;
    if (q.size() != 0 || q_s.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d/%0d pending writes, required 0/0",
               name, q.size(), q_s.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL %s_flags: got rdy/we/busy/done/err=%b, required 00000", name,
               {in_ready, mem_we, busy, done, err});
    end
    total++;
    if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL %s_mem: got addr=%h data=%h, required 00/00000000", name,
               mem_addr, mem_wdata);
    end
    total++;
    if (count !== 7'd0) begin
      bad++;
      $display("FAIL %s_count: got %0d, required 0", name, count);
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    total++;
    if (checksum !== 32'h0) begin
      bad++;
      $display("FAIL %s_checksum: got %h, required 0", name, checksum);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_add();
    do_start();
    total++;
    if ({busy, done, err, count} !== {3'b100, 7'd0}) begin
      bad++;
      $display("FAIL start_state: got busy/done/err/count=%b, required 100/0",
               {busy, done, err, count});
    end
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    total++;
    if (mem_addr !== 8'h00 || mem_wdata !== 32'h00221820 || count !== 7'd1) begin
      bad++;
      $display("FAIL add: got addr=%h data=%h count=%0d, required 00/00221820/1",
               mem_addr, mem_wdata, count);
    end
    idle(2);
    check_queue("add");
  endtask

  task automatic test_back_to_back();
    do_start();
    send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0);
    send(4'd7, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    total++;
    if (mem_addr !== 8'h08 || mem_wdata !== 32'h08000010 || count !== 7'd3) begin
      bad++;
      $display("FAIL b2b_last: got addr=%h data=%h count=%0d, required 08/08000010/3",
               mem_addr, mem_wdata, count);
    end
    idle(2);
    total++;
    if (mem_we !== 1'b0 || mem_wdata !== 32'h08000010) begin
      bad++;
      $display("FAIL wdata_hold: got we=%b data=%h, required 0/08000010", mem_we, mem_wdata);
    end
    check_queue("b2b");
  endtask

  task automatic test_illegal();
    do_start();
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0);
    send(4'd12, 5'd3, 5'd3, 5'd3, 16'h1234, 26'h0);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_err: got %b, required 1", err);
    end
    send(4'd8, 5'd3, 5'd4, 5'd0, 16'hFFF0, 26'h0);
    idle(2);
    total++;
    if (count !== 7'd2 || mem_addr !== 8'h04 || err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_end: got count=%0d addr=%h err=%b, required 2/04/1",
               count, mem_addr, err);
    end
    check_queue("illegal");
  endtask

  task automatic test_finish();
    do_start();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL start_clears_err: got %b, required 0", err);
    end
    send(4'd0, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
    finish   = 1;
    in_valid = 1;
    op_kind  = 4'd1;
    #1;
    total++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL finish_ready: got ready=%b done=%b, required 0/0", in_ready, done);
    end
    tick();
    finish   = 0;
    in_valid = 0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || count !== 7'd1) begin
      bad++;
      $display("FAIL finish_done: got done=%b busy=%b we=%b count=%0d, required 1/0/0/1",
               done, busy, mem_we, count);
    end
    idle(2);
    check_queue("finish");
  endtask

  task automatic test_start_mid();
    do_start();
    send(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    start    = 1;
    in_valid = 1;
    op_kind  = 4'd1;
    tick();
    start    = 0;
    in_valid = 0;
    exp_ptr  = '0;
    total++;
    if (mem_we !== 1'b0 || count !== 7'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_cancel: got we=%b count=%0d busy=%b, required 0/0/1",
               mem_we, count, busy);
    end
    send(4'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
    total++;
    if (mem_addr !== 8'h00 || count !== 7'd1) begin
      bad++;
      $display("FAIL restart_addr: got addr=%h count=%0d, required 00/1", mem_addr, count);
    end
    idle(2);
    check_queue("restart");
  endtask

  task automatic test_full();
    logic [31:0] w;
    s_start = 1;
    tick();
    s_start = 0;
    for (int i = 0; i < 5; i++) begin
      op_kind = 4'd0;
      rs = 5'(i); rt = 5'(i + 1); rd = 5'(i + 2);
      s_valid = 1;
      #1;
      total++;
      if (s_ready !== (i < 4)) begin
        bad++;
        $display("FAIL full_ready%0d: got %b, required %b", i, s_ready, (i < 4));
      end
      if (s_ready) begin
        w = model_enc(4'd0, rs, rt, rd, 16'h0, 26'h0);
        q_s.push_back('{addr: s_exp_ptr, data: w});
        s_exp_ptr += 8'd4;
        s_xor ^= w;
      end
      tick();
    end
    s_valid = 0;
    total++;
    if (s_count !== 3'd4 || s_done !== 1'b1 || s_ready !== 1'b0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL full_state: got count=%0d done=%b ready=%b busy=%b, required 4/1/0/0",
               s_count, s_done, s_ready, s_busy);
    end
    idle(2);
    total++;
    if (s_writes != 4 || s_max_addr !== 8'h0C || s_err !== 1'b0) begin
      bad++;
      $display("FAIL full_writes: got writes=%0d max_addr=%h err=%b, required 4/0c/0",
               s_writes, s_max_addr, s_err);
    end
`ifdef INSTR_ENC_CHECKSUM_EN
    total++;
    if (s_checksum !== s_xor) begin
      bad++;
      $display("FAIL full_checksum: got %h, required %h", s_checksum, s_xor);
    end
`endif
    check_queue("full");
  endtask

`ifdef INSTR_ENC_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    total++;
    if (checksum !== 32'h0) begin
      bad++;
      $display("FAIL checksum_clear: got %h, required 0", checksum);
    end
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0);
    total++;
    if (checksum !== 32'h8C2A1824) begin
      bad++;
      $display("FAIL checksum: got %h, required 8c2a1824", checksum);
    end
    idle(2);
    check_queue("checksum");
  endtask
`endif

  task automatic test_reset_mid();
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    rst_n = 0;
    #1;
    check_reset_outputs("reset_mid");
    q.delete();
    idle(1);
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_finish();
    test_start_mid();
    test_full();
`ifdef INSTR_ENC_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
